// File: rtl/cache_bus_arbiter_if.sv
// rtl/cache_bus_arbiter_if.sv - cache/bus request-response signal bundle for the line arbiter
// Purpose: carries the I-cache, D-cache and system-bus handshakes of cache_bus_arbiter.
// Ports (modports):
//   slave  - the arbiter view: takes cache requests and bus responses, drives acks,
//            cache responses and the forwarded bus request.
//   master - the environment view (caches plus bus), the mirror of slave.
interface cache_bus_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic [DATA_WIDTH-1:0] i_req,  d_req,  bus_req;
    logic [TAG_WIDTH-1:0]  i_reqtag, d_reqtag, bus_reqtag;
    logic                  i_reqcyc, d_reqcyc, bus_reqcyc;
    logic                  i_reqack, d_reqack, bus_reqack;
    logic [DATA_WIDTH-1:0] i_resp, d_resp, bus_resp;
    logic [TAG_WIDTH-1:0]  i_resptag, d_resptag, bus_resptag;
    logic                  i_respcyc, d_respcyc, bus_respcyc;
    logic                  i_respack, d_respack, bus_respack;

    modport slave (
        input  i_req, i_reqtag, i_reqcyc, i_respack,
        input  d_req, d_reqtag, d_reqcyc, d_respack,
        output i_reqack, i_resp, i_resptag, i_respcyc,
        output d_reqack, d_resp, d_resptag, d_respcyc,
        output bus_req, bus_reqtag, bus_reqcyc, bus_respack,
        input  bus_reqack, bus_resp, bus_resptag, bus_respcyc
    );

    modport master (
        output i_req, i_reqtag, i_reqcyc, i_respack,
        output d_req, d_reqtag, d_reqcyc, d_respack,
        input  i_reqack, i_resp, i_resptag, i_respcyc,
        input  d_reqack, d_resp, d_resptag, d_respcyc,
        input  bus_req, bus_reqtag, bus_reqcyc, bus_respack,
        output bus_reqack, bus_resp, bus_resptag, bus_respcyc
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin I/D cache line-request arbiter onto one system bus
// Purpose: grants one cache at a time, forwards its address/write beats to the bus and
//          steers read response beats back to it; one transaction outstanding.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus_if - cache_bus_arbiter_if.slave: both cache ports and the system bus port
//   err    - sticky flag: a bus response arrived unexpectedly or with the wrong tag
module cache_bus_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_bus_arbiter_if.slave   bus_if,
    output logic                 err
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic INSTR = 1'b0;
    localparam logic DATA  = 1'b1;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RWAIT} state_t;

    state_t        state, state_d;
    logic          owner, last_grant, rw;
    logic [CW-1:0] beat_cnt;

    logic do_grant, grant_id, grant_rw;
    logic req_hs, resp_hs, beat_adv, spurious, mismatch;
    logic [DATA_WIDTH-1:0] sel_req;
    logic [TAG_WIDTH-1:0]  sel_reqtag;
    logic                  sel_reqcyc, sel_respack;

    always_comb begin
        state_d  = state;
        do_grant = 1'b0;
        grant_id = INSTR;
        grant_rw = 1'b0;
        req_hs   = 1'b0;
        resp_hs  = 1'b0;
        spurious = 1'b0;
        mismatch = 1'b0;

        bus_if.i_reqack    = 1'b0;
        bus_if.d_reqack    = 1'b0;
        bus_if.i_resp      = '0;
        bus_if.d_resp      = '0;
        bus_if.i_resptag   = '0;
        bus_if.d_resptag   = '0;
        bus_if.i_respcyc   = 1'b0;
        bus_if.d_respcyc   = 1'b0;
        bus_if.bus_req     = '0;
        bus_if.bus_reqtag  = '0;
        bus_if.bus_reqcyc  = 1'b0;
        bus_if.bus_respack = 1'b0;

        sel_req     = owner ? bus_if.d_req     : bus_if.i_req;
        sel_reqtag  = owner ? bus_if.d_reqtag  : bus_if.i_reqtag;
        sel_reqcyc  = owner ? bus_if.d_reqcyc  : bus_if.i_reqcyc;
        sel_respack = owner ? bus_if.d_respack : bus_if.i_respack;

        case (state)
            IDLE: begin
                if (bus_if.i_reqcyc || bus_if.d_reqcyc) begin
                    do_grant = 1'b1;
                    // Contention goes to whoever did not win last time.
                    grant_id = (bus_if.i_reqcyc && bus_if.d_reqcyc) ? ~last_grant
                                                                    : bus_if.d_reqcyc;
                    grant_rw = grant_id ? bus_if.d_reqtag[TAG_WIDTH-1]
                                        : bus_if.i_reqtag[TAG_WIDTH-1];
                    state_d  = ADDR;
                end
            end
            ADDR, WDATA: begin
                bus_if.bus_req    = sel_req;
                // Bit 0 names the requester so the response can be checked on return.
                bus_if.bus_reqtag = {sel_reqtag[TAG_WIDTH-1:1], owner};
                bus_if.bus_reqcyc = sel_reqcyc;
                if (owner) bus_if.d_reqack = bus_if.bus_reqack;
                else       bus_if.i_reqack = bus_if.bus_reqack;
                req_hs = sel_reqcyc && bus_if.bus_reqack;
                if (req_hs) begin
                    if (state == ADDR)              state_d = rw ? RWAIT : WDATA;
                    else if (beat_cnt == LAST_BEAT) state_d = IDLE;
                end
            end
            RWAIT: begin
                if (owner) begin
                    bus_if.d_respcyc = bus_if.bus_respcyc;
                    bus_if.d_resp    = bus_if.bus_resp;
                    bus_if.d_resptag = bus_if.bus_resptag;
                end else begin
                    bus_if.i_respcyc = bus_if.bus_respcyc;
                    bus_if.i_resp    = bus_if.bus_resp;
                    bus_if.i_resptag = bus_if.bus_resptag;
                end
                bus_if.bus_respack = sel_respack;
                resp_hs  = bus_if.bus_respcyc && sel_respack;
                mismatch = bus_if.bus_respcyc && (bus_if.bus_resptag[0] != owner);
                if (resp_hs && beat_cnt == LAST_BEAT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nobody is waiting for a response outside RWAIT: swallow it so the bus cannot hang.
        if (state != RWAIT && bus_if.bus_respcyc) begin
            bus_if.bus_respack = 1'b1;
            spurious           = 1'b1;
        end

        beat_adv = (state == WDATA && req_hs) || (state == RWAIT && resp_hs);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= INSTR;
            last_grant <= DATA;
            rw         <= 1'b0;
            beat_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_d;
            if (do_grant) begin
                owner <= grant_id;
                rw    <= grant_rw;
            end
            if (state == ADDR && req_hs) begin
                last_grant <= owner;
                beat_cnt   <= '0;
            end else if (beat_adv) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            end
            if (spurious || mismatch) err <= 1'b1;
        end
    end
endmodule
